// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data-memory port between the
// MEM stage of the pipeline and an external host (debugger / program loader).
// The pipeline normally has priority; a starvation counter forces the host
// through after STARVE_LIMIT waiting cycles, and host_lock excludes the
// pipeline entirely while a program is being loaded.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // host side
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    // pipeline MEM stage
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FORCE  = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        rd_host_reg, rd_pipe_reg;
    logic        grant_host, grant_pipe;

    // Grant selection: at most one requester per cycle, nothing while in reset.
    always_comb begin
        grant_host = 1'b0;
        grant_pipe = 1'b0;
        if (!rst) begin
            case (state_reg)
                NORMAL: begin
                    if (pipe_req)      grant_pipe = 1'b1;
                    else if (host_req) grant_host = 1'b1;
                end
                FORCE: begin
                    if (host_req)      grant_host = 1'b1;
                    else if (pipe_req) grant_pipe = 1'b1;
                end
                default: begin
                    // LOCK: the pipeline is shut out completely
                    if (host_req)      grant_host = 1'b1;
                end
            endcase
        end
    end

    // Memory port mux: the granted requester owns the port, all zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_host) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (grant_pipe) begin
            mem_en    = 1'b1;
            mem_we    = pipe_we;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end
    end

    assign host_gnt   = grant_host;
    assign pipe_stall = pipe_req & ~grant_pipe;

    // Next-state and starvation-counter logic; host_lock overrides everything.
    always_comb begin
        if (host_req && !grant_host)
            starve_cnt_next = (starve_cnt_reg >= LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
        else
            starve_cnt_next = '0;

        state_next = NORMAL;
        if (host_lock) begin
            state_next = LOCK;
        end else begin
            case (state_reg)
                NORMAL: begin
                    if (starve_cnt_next == LIMIT) state_next = FORCE;
                end
                FORCE: begin
                    // the forced slot lasts exactly one cycle
                    state_next = NORMAL;
                end
                default: begin
                    // leaving LOCK starts the host with a clean slate
                    state_next      = NORMAL;
                    starve_cnt_next = '0;
                end
            endcase
        end
    end

    // State, counter and read-owner registers; the owner tags the returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= NORMAL;
            starve_cnt_reg <= '0;
            rd_host_reg    <= 1'b0;
            rd_pipe_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            rd_host_reg    <= grant_host & ~host_we;
            rd_pipe_reg    <= grant_pipe & ~pipe_we;
        end
    end

    assign host_rvalid = rd_host_reg;
    assign pipe_rvalid = rd_pipe_reg;

    // Steer returning read data to its owner only; the other side sees zero.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rdata
            assign host_rdata[gi] = mem_rdata[gi] & rd_host_reg;
            assign pipe_rdata[gi] = mem_rdata[gi] & rd_pipe_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: the bench provides the synchronous-read memory,
// a cycle model of the arbitration rules, and a scoreboard of read responses.
module tb_dmem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_we, host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          pipe_req, pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata;
    logic          pipe_stall, pipe_rvalid;
    logic [DW-1:0] pipe_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
        .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // the data memory driven by the DUT port
    logic [DW-1:0] mem    [0:255];
    // expected memory contents, updated from the model's expected grants
    logic [DW-1:0] shadow [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic          host;
        logic [DW-1:0] data;
    } rd_t;

    rd_t rq[$];

    int vectors     = 0;
    int miscompares = 0;

    // model state: 0 NORMAL, 1 FORCE, 2 LOCK
    int m_state = 0, m_cnt = 0, m_state_n = 0, m_cnt_n = 0;
    bit exp_hg, exp_pg, obs_hg, obs_stall;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // compare combinational outputs against the model and book expected effects
    task automatic eval_cycle();
        bit hg, pg;
        int nc, ns;
        hg = 0; pg = 0;
        if (!rst) begin
            if (m_state == 0) begin
                if (pipe_req) pg = 1; else if (host_req) hg = 1;
            end else if (m_state == 1) begin
                if (host_req) hg = 1; else if (pipe_req) pg = 1;
            end else begin
                if (host_req) hg = 1;
            end
        end
        exp_hg    = hg;
        exp_pg    = pg;
        obs_hg    = host_gnt;
        obs_stall = pipe_stall;
        chk("host_gnt",   DW'(host_gnt),   DW'(hg));
        chk("pipe_stall", DW'(pipe_stall), DW'(pipe_req && !pg));
        chk("mem_en",     DW'(mem_en),     DW'(hg || pg));
        chk("mem_we",     DW'(mem_we),     DW'(hg ? host_we : (pg ? pipe_we : 1'b0)));
        chk("mem_addr",   DW'(mem_addr),   DW'(hg ? host_addr : (pg ? pipe_addr : 8'h00)));
        chk("mem_wdata",  mem_wdata,       hg ? host_wdata : (pg ? pipe_wdata : 32'h0));
        if (hg) begin
            if (host_we) shadow[host_addr] = host_wdata;
            else rq.push_back('{1'b1, shadow[host_addr]});
        end
        if (pg) begin
            if (pipe_we) shadow[pipe_addr] = pipe_wdata;
            else rq.push_back('{1'b0, shadow[pipe_addr]});
        end
        if (host_req && !hg) nc = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
        else nc = 0;
        if (host_lock) ns = 2;
        else if (m_state == 2) begin ns = 0; nc = 0; end
        else if (m_state == 1) ns = 0;
        else ns = (nc == LIM) ? 1 : 0;
        m_state_n = ns;
        m_cnt_n   = nc;
    endtask

    // compare read responses for the access issued in the previous cycle
    task automatic check_resp();
        rd_t e;
        if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("host_rvalid", DW'(host_rvalid), DW'(e.host));
            chk("pipe_rvalid", DW'(pipe_rvalid), DW'(!e.host));
            chk("host_rdata",  host_rdata, e.host ? e.data : 32'h0);
            chk("pipe_rdata",  pipe_rdata, e.host ? 32'h0 : e.data);
            $display("rd %s data=%08h", e.host ? "host" : "pipe", e.host ? host_rdata : pipe_rdata);
        end else begin
            chk("host_rvalid_idle", DW'(host_rvalid), 0);
            chk("pipe_rvalid_idle", DW'(pipe_rvalid), 0);
            chk("host_rdata_idle",  host_rdata, 0);
            chk("pipe_rdata_idle",  pipe_rdata, 0);
        end
    endtask

    // one clock cycle: drive at negedge, check mid-cycle, response at next negedge
    task automatic step(input logic hr, input logic hw, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input logic hl,
                        input logic pr, input logic pw, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd);
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
        pipe_req = pr; pipe_we = pw; pipe_addr = pa; pipe_wdata = pd;
        #1;
        eval_cycle();
        @(posedge clk);
        m_state = m_state_n;
        m_cnt   = m_cnt_n;
        @(negedge clk);
        check_resp();
    endtask

    task automatic idle(input logic hl);
        step(0, 0, 8'h00, 32'h0, hl, 0, 0, 8'h00, 32'h0);
    endtask

    logic          h_pend, h_we, h_lock, p_pend, p_we;
    logic [AW-1:0] h_addr, p_addr;
    logic [DW-1:0] h_data, p_data;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
            shadow[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        end
        mem[8'h10] = 32'hDEADBEEF; shadow[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFEF00D; shadow[8'h20] = 32'hCAFEF00D;
        mem_rdata = '0;

        // reset with requests present and no clock edge yet
        rst = 1'b1;
        host_req = 1; host_we = 1; host_addr = 8'h33; host_wdata = 32'h1234; host_lock = 0;
        pipe_req = 1; pipe_we = 1; pipe_addr = 8'h44; pipe_wdata = 32'h5678;
        #3;
        chk("rst_host_gnt",    DW'(host_gnt), 0);
        chk("rst_mem_en",      DW'(mem_en), 0);
        chk("rst_mem_we",      DW'(mem_we), 0);
        chk("rst_mem_addr",    DW'(mem_addr), 0);
        chk("rst_mem_wdata",   mem_wdata, 0);
        chk("rst_pipe_stall",  DW'(pipe_stall), 1);
        chk("rst_host_rvalid", DW'(host_rvalid), 0);
        chk("rst_pipe_rvalid", DW'(pipe_rvalid), 0);
        host_req = 0; pipe_req = 0;
        @(negedge clk);
        rst = 1'b0;

        // simple pipeline load
        step(0, 0, 8'h00, 32'h0, 0, 1, 0, 8'h10, 32'h0);
        chk("t39_stall",  DW'(obs_stall), 0);
        chk("t39_rvalid", DW'(pipe_rvalid), 1);
        chk("t39_rdata",  pipe_rdata, 32'hDEADBEEF);
        idle(0);

        // starvation: host read of 0x20 forced through in cycle 4
        for (int i = 0; i < 6; i++) begin
            step(i <= 4, 0, 8'h20, 32'h0, 0, 1, 0, AW'(8'h60 + (i < 4 ? i : 4)), 32'h0);
            chk("t40_host_gnt",   DW'(obs_hg),    DW'(i == 4));
            chk("t40_pipe_stall", DW'(obs_stall), DW'(i == 4));
            if (i == 4) begin
                chk("t42_host_rvalid", DW'(host_rvalid), 1);
                chk("t42_pipe_rvalid", DW'(pipe_rvalid), 0);
                chk("t42_host_rdata",  host_rdata, 32'hCAFEF00D);
            end
            if (i == 5) begin
                chk("t42_pipe_rvalid2", DW'(pipe_rvalid), 1);
                chk("t42_host_rvalid2", DW'(host_rvalid), 0);
            end
        end
        idle(0);

        // lock: host writes while the pipeline waits for the same word
        idle(1);
        step(1, 1, 8'h03, 32'h5, 1, 1, 0, 8'h03, 32'h0);
        chk("t41_stall_a", DW'(obs_stall), 1);
        chk("t41_hgnt",    DW'(obs_hg), 1);
        step(0, 0, 8'h00, 32'h0, 1, 1, 0, 8'h03, 32'h0);
        chk("t41_stall_b", DW'(obs_stall), 1);
        step(0, 0, 8'h00, 32'h0, 0, 1, 0, 8'h03, 32'h0);
        chk("t41_stall_c", DW'(obs_stall), 1);
        step(0, 0, 8'h00, 32'h0, 0, 1, 0, 8'h03, 32'h0);
        chk("t41_stall_d", DW'(obs_stall), 0);
        chk("t41_rvalid",  DW'(pipe_rvalid), 1);
        chk("t41_rdata",   pipe_rdata, 32'h5);
        idle(0);

        // reset in the cycle after a read issue discards the response
        step(0, 0, 8'h00, 32'h0, 0, 1, 0, 8'h10, 32'h0);
        host_req = 0; pipe_req = 0;
        rst = 1'b1;
        #1;
        chk("t43_host_rvalid", DW'(host_rvalid), 0);
        chk("t43_pipe_rvalid", DW'(pipe_rvalid), 0);
        chk("t43_pipe_rdata",  pipe_rdata, 0);
        rq.delete();
        m_state = 0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 8'h70, 32'hA5A5A5A5, 0, 1, 1, AW'(8'h71 + i), 32'(i));
            chk("t43_host_gnt", DW'(obs_hg), DW'(i == 4));
        end
        idle(0);

        // randomized traffic against the model and scoreboard
        h_pend = 0; p_pend = 0; h_lock = 0;
        h_we = 0; p_we = 0; h_addr = '0; p_addr = '0; h_data = '0; p_data = '0;
        for (int n = 0; n < 400; n++) begin
            if (!h_pend && $urandom_range(0, 9) < 4) begin
                h_pend = 1; h_we = 1'($urandom_range(0, 1));
                h_addr = AW'($urandom_range(0, 7)); h_data = $urandom;
            end
            if (!p_pend && $urandom_range(0, 9) < 6) begin
                p_pend = 1; p_we = 1'($urandom_range(0, 1));
                p_addr = AW'($urandom_range(0, 7)); p_data = $urandom;
            end
            if ($urandom_range(0, 24) == 0) h_lock = ~h_lock;
            step(h_pend, h_we, h_addr, h_data, h_lock, p_pend, p_we, p_addr, p_data);
            if (exp_hg) h_pend = 0;
            if (exp_pg) p_pend = 0;
        end
        idle(0);
        idle(0);
        chk("drain", DW'(rq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
